// File: rtl/norm_sub_block.sv
// rtl/norm_sub_block.sv - final softmax stage: buffer (x_i - max), then stream minus ln(sum(exp))
// Optional macro NORM_SAT_EN: clamp out-of-range differences instead of wrapping.
module norm_sub_block #(
  parameter int data_size      = 32,
  parameter int number_of_data = 10
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic [data_size-1:0] sub_result_i,
  input  logic                 sub_result_valid_i,
  input  logic [data_size-1:0] ln_data_i,
  input  logic                 ln_data_valid_i,
  output logic [data_size-1:0] norm_data_o,
  output logic                 norm_data_valid_o,
  output logic                 norm_done_o,
  output logic                 overflow_o
);

  localparam int CW = $clog2(number_of_data + 1);
  localparam logic [CW-1:0] LAST = CW'(number_of_data - 1);

  typedef enum logic [1:0] {COLLECT, WAIT_LN, DRAIN} state_t;

  state_t                 state, state_next;
  logic [data_size-1:0]   data_buf [number_of_data];
  logic [CW-1:0]          wr_cnt, rd_cnt;
  logic                   ln_latched;
  logic [data_size-1:0]   ln_reg;
  logic signed [data_size:0] diff;
  logic [data_size-1:0]   result;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) state <= COLLECT;
    else         state <= state_next;
  end

  // The write that fills the buffer decides between DRAIN and WAIT_LN on the same edge.
  always_comb begin
    state_next = state;
    case (state)
      COLLECT: begin
        if (sub_result_valid_i && wr_cnt == LAST)
          state_next = (ln_latched || ln_data_valid_i) ? DRAIN : WAIT_LN;
      end
      WAIT_LN: begin
        if (ln_data_valid_i) state_next = DRAIN;
      end
      DRAIN: begin
        if (rd_cnt == LAST) state_next = COLLECT;
      end
      default: state_next = COLLECT;
    endcase
  end

  always_comb begin
    diff = {data_buf[rd_cnt][data_size-1], data_buf[rd_cnt]}
         - {ln_reg[data_size-1], ln_reg};
`ifdef NORM_SAT_EN
    if (diff[data_size] != diff[data_size-1])
      result = diff[data_size] ? {1'b1, {(data_size-1){1'b0}}}
                               : {1'b0, {(data_size-1){1'b1}}};
    else
      result = diff[data_size-1:0];
`else
    result = diff[data_size-1:0];
`endif
  end

  // Buffer contents are don't-care after reset, so no reset term here.
  always_ff @(posedge clock_i) begin
    if (state == COLLECT && sub_result_valid_i)
      data_buf[wr_cnt] <= sub_result_i;
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      wr_cnt            <= '0;
      rd_cnt            <= '0;
      ln_latched        <= 1'b0;
      ln_reg            <= '0;
      norm_data_o       <= '0;
      norm_data_valid_o <= 1'b0;
      norm_done_o       <= 1'b0;
      overflow_o        <= 1'b0;
    end else begin
      norm_data_valid_o <= 1'b0;
      norm_done_o       <= 1'b0;
      case (state)
        COLLECT: begin
          if (sub_result_valid_i) wr_cnt <= wr_cnt + CW'(1);
          if (ln_data_valid_i) begin
            if (ln_latched) begin
              overflow_o <= 1'b1;
            end else begin
              ln_reg     <= ln_data_i;
              ln_latched <= 1'b1;
            end
          end
        end
        WAIT_LN: begin
          if (sub_result_valid_i) overflow_o <= 1'b1;
          if (ln_data_valid_i) begin
            ln_reg     <= ln_data_i;
            ln_latched <= 1'b1;
          end
        end
        DRAIN: begin
          norm_data_o       <= result;
          norm_data_valid_o <= 1'b1;
          rd_cnt            <= rd_cnt + CW'(1);
          if (sub_result_valid_i || ln_data_valid_i) overflow_o <= 1'b1;
          if (rd_cnt == LAST) begin
            norm_done_o <= 1'b1;
            wr_cnt      <= '0;
            rd_cnt      <= '0;
            ln_latched  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_norm_sub_block.sv
// tb/tb_norm_sub_block.sv - scoreboard bench for norm_sub_block
// Honours NORM_SAT_EN when choosing expected clamp/wrap results.
module tb_norm_sub_block;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] sub_data, ln_data, norm_data;
  logic        sub_valid, ln_valid, norm_valid, norm_done, overflow;

  int total = 0;
  int bad   = 0;
  int run   = 0;
  int exp_run = 10;
  logic [32:0] exp_q[$];
  logic [32:0] mon_got, mon_want;
  logic [31:0] vec [10];

  always #5 clk = ~clk;

  norm_sub_block #(.data_size(32), .number_of_data(10)) dut (
    .clock_i           (clk),
    .reset_i           (rst),
    .sub_result_i      (sub_data),
    .sub_result_valid_i(sub_valid),
    .ln_data_i         (ln_data),
    .ln_data_valid_i   (ln_valid),
    .norm_data_o       (norm_data),
    .norm_data_valid_o (norm_valid),
    .norm_done_o       (norm_done),
    .overflow_o        (overflow)
  );

  function automatic logic [31:0] ref_sub(input logic [31:0] a, input logic [31:0] b);
    logic signed [32:0] d;
    d = $signed({a[31], a}) - $signed({b[31], b});
`ifdef NORM_SAT_EN
    if (d > 33'sd2147483647)       return 32'h7FFF_FFFF;
    else if (d < -33'sd2147483648) return 32'h8000_0000;
`endif
    return d[31:0];
  endfunction

  always @(negedge clk) begin
    if (norm_valid) begin
      mon_got = {norm_done, norm_data};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output got=%h want=none", mon_got);
      end else begin
        mon_want = exp_q.pop_front();
        if (mon_got !== mon_want) begin
          bad++;
          $display("FAIL out_word got done/data=%h want=%h", mon_got, mon_want);
        end
      end
      run++;
    end else if (run != 0) begin
      total++;
      if (run != exp_run) begin
        bad++;
        $display("FAIL burst_length got=%0d want=%0d", run, exp_run);
      end
      run = 0;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic drive_sub(input logic [31:0] d);
    sub_data = d; sub_valid = 1'b1;
    tick();
    sub_valid = 1'b0;
  endtask

  task automatic drive_ln(input logic [31:0] d);
    ln_data = d; ln_valid = 1'b1;
    tick();
    ln_valid = 1'b0;
  endtask

  task automatic push_basic;
    for (int i = 0; i < 10; i++)
      exp_q.push_back({(i == 9), 32'hFFFE_0000 - (32'(i) << 16)});
  endtask

  task automatic push_model(input logic [31:0] ln);
    for (int i = 0; i < 10; i++)
      exp_q.push_back({(i == 9), ref_sub(vec[i], ln)});
  endtask

  task automatic check_latency(input string name);
    check({name, "_pre"}, {31'd0, norm_valid}, 32'd0);
    tick();
    check({name, "_first"}, {31'd0, norm_valid}, 32'd1);
  endtask

  task automatic send_basic;
    for (int i = 0; i < 10; i++) drive_sub(32'h0 - (32'(i) << 16));
  endtask

  initial begin
    rst = 1'b1; sub_data = '0; sub_valid = 1'b0; ln_data = '0; ln_valid = 1'b0;
    idle(2);
    check("rst_data", norm_data, 32'd0);
    check("rst_valid", {31'd0, norm_valid}, 32'd0);
    check("rst_done", {31'd0, norm_done}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    rst = 1'b0;
    idle(2);

    // basic vector, ln two cycles after the last input
    push_basic();
    send_basic();
    idle(1);
    drive_ln(32'h0002_0000);
    check_latency("basic");
    idle(12);
    check("basic_ovf", {31'd0, overflow}, 32'd0);

    // early ln with gapped inputs
    for (int i = 0; i < 10; i++) vec[i] = 32'h0003_0000 + 32'(i) * 32'h0000_1100;
    push_model(32'h0001_8000);
    for (int i = 0; i < 10; i++) begin
      drive_sub(vec[i]);
      if (i == 2) drive_ln(32'h0001_8000);
      else if (i < 9) idle(1);
    end
    check_latency("early_ln");
    idle(12);

    // last input and ln on the same edge
    for (int i = 0; i < 10; i++) vec[i] = 32'hFFF0_0000 + 32'(i) * 32'h0002_0000;
    push_model(32'h0000_4000);
    for (int i = 0; i < 9; i++) drive_sub(vec[i]);
    sub_data = vec[9]; sub_valid = 1'b1; ln_data = 32'h0000_4000; ln_valid = 1'b1;
    tick();
    sub_valid = 1'b0; ln_valid = 1'b0;
    check_latency("same_cycle");
    idle(12);

    // saturation / wrap at the negative limit
    vec[0] = 32'h8000_0000;
`ifdef NORM_SAT_EN
    exp_q.push_back({1'b0, 32'h8000_0000});
`else
    exp_q.push_back({1'b0, 32'h7FFF_0000});
`endif
    for (int i = 1; i < 10; i++) begin
      vec[i] = 32'(i) << 16;
      exp_q.push_back({(i == 9), 32'(i - 1) << 16});
    end
    for (int i = 0; i < 10; i++) drive_sub(vec[i]);
    drive_ln(32'h0001_0000);
    idle(13);
    check("sat_ovf", {31'd0, overflow}, 32'd0);

    // protocol violations: extra input in WAIT_LN, second ln in DRAIN
    push_basic();
    send_basic();
    drive_sub(32'h1234_5678);
    check("ovf_wait_ln", {31'd0, overflow}, 32'd1);
    drive_ln(32'h0002_0000);
    tick();
    drive_ln(32'h0005_0000);
    idle(12);
    check("ovf_sticky", {31'd0, overflow}, 32'd1);
    push_basic();
    send_basic();
    drive_ln(32'h0002_0000);
    idle(13);
    check("ovf_still", {31'd0, overflow}, 32'd1);

    // reset during DRAIN after four outputs
    exp_run = 4;
    push_basic();
    send_basic();
    drive_ln(32'h0002_0000);
    idle(4);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", {31'd0, norm_valid}, 32'd0);
    check("mid_rst_data", norm_data, 32'd0);
    check("mid_rst_done", {31'd0, norm_done}, 32'd0);
    check("mid_rst_ovf", {31'd0, overflow}, 32'd0);
    exp_q.delete();
    idle(2);
    exp_run = 10;
    rst = 1'b0;
    idle(3);
    for (int i = 0; i < 10; i++) vec[i] = 32'h0010_0000 - 32'(i) * 32'h0000_3000;
    push_model(32'h0000_8000);
    for (int i = 0; i < 10; i++) drive_sub(vec[i]);
    drive_ln(32'h0000_8000);
    idle(13);
    check("post_rst_ovf", {31'd0, overflow}, 32'd0);

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
    check("drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
